// File: rtl/proc_param_pkg.sv
// Shared definitions for the proc_param core: controller states, opcodes,
// instruction field positions and small opcode-class helpers.
package proc_param_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int DEST_MSB = 11;
   localparam int DEST_LSB = 9;
   localparam int SRC1_MSB = 8;
   localparam int SRC1_LSB = 6;
   localparam int SRC2_MSB = 5;
   localparam int SRC2_LSB = 3;
   localparam int IMM_MSB  = 8;
   localparam int IMM_LSB  = 0;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_LDI  = 4'd8;
   localparam logic [3:0] OP_LD   = 4'd9;
   localparam logic [3:0] OP_ST   = 4'd10;
   localparam logic [3:0] OP_BZ   = 4'd11;
   localparam logic [3:0] OP_JMP  = 4'd12;
   localparam logic [3:0] OP_CMP  = 4'd13;
   localparam logic [3:0] OP_NOP2 = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   // ALU operations that write their result back to the register file
   function automatic logic is_alu_write(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_SHR);
   endfunction

   // Arithmetic operations that update all four flags
   function automatic logic is_flag_arith(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
   endfunction

   // Logic and shift operations: Z/N from the result, V/C cleared
   function automatic logic is_flag_logic(input logic [3:0] op);
      return (op >= OP_AND) && (op <= OP_SHR);
   endfunction

endpackage

// File: rtl/proc_param_if.sv
// Instruction-fetch and data-memory bus of the proc_param core.
// The core drives the master side; memories (or a bench) take the slave side.
interface proc_param_if #(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 7,
   parameter int DMEM_AW = 7
);

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [15:0]        imem_rdata;
   logic               imem_valid;

   logic               dmem_re;
   logic               dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic [DATA_W-1:0]  dmem_rdata;
   logic               dmem_valid;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata, imem_valid,
      output dmem_re, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_valid
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata, imem_valid,
      input  dmem_re, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_valid
   );

endinterface

// File: rtl/proc_param_alu.sv
// Combinational datapath of proc_param: arithmetic, logic and shift
// operations plus the Z/N/V/C values they produce.
module proc_param_alu
   import proc_param_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int SH_W   = $clog2(DATA_W)
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [SH_W-1:0]   shamt,
   output logic [DATA_W-1:0] y,
   output logic              z,
   output logic              n,
   output logic              v,
   output logic              c
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = a - b;

   // Select the operation result; subtraction carry means "no borrow"
   always_comb begin
      y = '0;
      v = 1'b0;
      c = 1'b0;
      case (op)
         OP_ADD: begin
            y = sum[DATA_W-1:0];
            c = sum[DATA_W];
            v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB, OP_CMP: begin
            y = diff;
            c = (a >= b);
            v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_SHL: y = a << shamt;
         OP_SHR: y = a >> shamt;
         default: y = '0;
      endcase
      z = (y == '0);
      n = y[MSB];
   end

endmodule

// File: rtl/proc_param.sv
// proc_param: small multi-cycle load/store core with an 8-entry register
// file, a 16-bit instruction fetch bus and a single-word data memory bus.
module proc_param
   import proc_param_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 7,
   parameter int DMEM_AW = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   proc_param_if.master      bus,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              zero,
   output logic              negative,
   output logic              overflow,
   output logic              carry,
   output logic              busy,
   output logic              halted
);

   localparam int SH_W = $clog2(DATA_W);

   state_t            state;
   state_t            state_next;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   pc_exec_next;
   logic [15:0]       instr;
   logic [DATA_W-1:0] regs [8];
   logic [DATA_W-1:0] last_result;

   logic [3:0]        opcode;
   logic [2:0]        dest;
   logic [2:0]        src1;
   logic [2:0]        src2;
   logic [8:0]        imm9;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] imm_ext;

   logic [DATA_W-1:0] alu_y;
   logic              alu_z;
   logic              alu_n;
   logic              alu_v;
   logic              alu_c;

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;

   assign opcode  = instr[OPC_MSB:OPC_LSB];
   assign dest    = instr[DEST_MSB:DEST_LSB];
   assign src1    = instr[SRC1_MSB:SRC1_LSB];
   assign src2    = instr[SRC2_MSB:SRC2_LSB];
   assign imm9    = instr[IMM_MSB:IMM_LSB];
   assign op_a    = regs[src1];
   assign op_b    = regs[src2];
   assign imm_ext = DATA_W'(imm9);

   proc_param_alu #(
      .DATA_W (DATA_W)
   ) alu (
      .op    (opcode),
      .a     (op_a),
      .b     (op_b),
      .shamt (op_b[SH_W-1:0]),
      .y     (alu_y),
      .z     (alu_z),
      .n     (alu_n),
      .v     (alu_v),
      .c     (alu_c)
   );

   // Controller state register; reset wins over everything, including start
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Controller transitions; memory handshakes hold the state until valid
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.imem_valid) begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if ((opcode == OP_LD) || (opcode == OP_ST)) begin
               state_next = S_MEM;
            end else if (opcode == OP_HALT) begin
               state_next = S_HALT;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_MEM: begin
            if (bus.dmem_valid) begin
               state_next = S_FETCH;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Next PC after EXEC; BZ looks at the flags as they were before it ran
   always_comb begin
      pc_exec_next = pc + PC_W'(1);
      if ((opcode == OP_JMP) || ((opcode == OP_BZ) && zero)) begin
         pc_exec_next = imm9[PC_W-1:0];
      end
   end

   // Register-file write port; a reset cycle never commits a write
   always_comb begin
      wr_en   = 1'b0;
      wr_data = alu_y;
      if (!rst) begin
         if (state == S_EXEC) begin
            if (is_alu_write(opcode)) begin
               wr_en   = 1'b1;
               wr_data = alu_y;
            end else if (opcode == OP_LDI) begin
               wr_en   = 1'b1;
               wr_data = imm_ext;
            end
         end else if ((state == S_MEM) && (opcode == OP_LD) && bus.dmem_valid) begin
            wr_en   = 1'b1;
            wr_data = bus.dmem_rdata;
         end
      end
   end

   // Architectural state: PC, instruction latch, registers and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= '0;
         instr       <= '0;
         last_result <= '0;
         zero        <= 1'b0;
         negative    <= 1'b0;
         overflow    <= 1'b0;
         carry       <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc <= '0;
               end
            end
            S_FETCH: begin
               if (bus.imem_valid) begin
                  instr <= bus.imem_rdata;
               end
            end
            S_EXEC: begin
               pc <= pc_exec_next;
               if (is_flag_arith(opcode)) begin
                  zero     <= alu_z;
                  negative <= alu_n;
                  overflow <= alu_v;
                  carry    <= alu_c;
               end else if (is_flag_logic(opcode)) begin
                  zero     <= alu_z;
                  negative <= alu_n;
                  overflow <= 1'b0;
                  carry    <= 1'b0;
               end
            end
            default: ;
         endcase
         if (wr_en) begin
            regs[dest]  <= wr_data;
            last_result <= wr_data;
         end
      end
   end

   // Bus strobes, status and result follow directly from the current state
   always_comb begin
      busy           = 1'b0;
      halted         = 1'b0;
      bus.imem_req   = 1'b0;
      bus.imem_addr  = '0;
      bus.dmem_re    = 1'b0;
      bus.dmem_we    = 1'b0;
      bus.dmem_addr  = '0;
      bus.dmem_wdata = '0;
      result_valid   = wr_en;
      result         = wr_en ? wr_data : last_result;
      case (state)
         S_FETCH: begin
            busy          = 1'b1;
            bus.imem_req  = 1'b1;
            bus.imem_addr = pc;
         end
         S_EXEC: begin
            busy = 1'b1;
         end
         S_MEM: begin
            busy           = 1'b1;
            bus.dmem_re    = (opcode == OP_LD);
            bus.dmem_we    = (opcode == OP_ST);
            bus.dmem_addr  = op_a[DMEM_AW-1:0];
            bus.dmem_wdata = op_b;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_proc_param.sv
// Self-checking bench for proc_param (DATA_W=16, PC_W=7, DMEM_AW=7):
// directed programs plus random programs scored against an ISA-level model.
module tb_proc_param;
   import proc_param_pkg::*;

   localparam int DW = 16;
   localparam int PW = 7;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] result;
   logic          result_valid;
   logic          zero, negative, overflow, carry;
   logic          busy, halted;

   proc_param_if #(.DATA_W(DW), .PC_W(PW), .DMEM_AW(AW)) bus ();

   proc_param #(.DATA_W(DW), .PC_W(PW), .DMEM_AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus),
      .result       (result),
      .result_valid (result_valid),
      .zero         (zero),
      .negative     (negative),
      .overflow     (overflow),
      .carry        (carry),
      .busy         (busy),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   logic [15:0] imem [128];
   logic [15:0] dmem [128];
   logic [15:0] mdm  [128];
   logic [15:0] mregs [8];
   logic        mz, mn, mv, mc;
   logic [15:0] m_last;
   bit          model_overrun;

   int exp_fetch[$];
   int exp_result[$];
   int fetch_log[$];
   int req_len_q[$];

   int errors = 0;
   int checks = 0;
   int iwait_fixed = -1;
   int dwait_fixed = -1;
   bit dmem_auto = 1'b1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] encR(input logic [3:0] op, input int d, input int s1, input int s2);
      return {op, 3'(d), 3'(s1), 3'(s2), 3'b000};
   endfunction

   function automatic logic [15:0] encI(input logic [3:0] op, input int d, input int imm);
      return {op, 3'(d), 9'(imm)};
   endfunction

   function automatic int sgn(input logic [15:0] x);
      return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
   endfunction

   function automatic void modelWrite(input int d, input logic [15:0] y);
      mregs[d] = y;
      m_last   = y;
      exp_result.push_back(int'(y));
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
      {mz, mn, mv, mc} = 4'b0000;
      m_last = 16'h0;
   endfunction

   // ISA-level reference: runs the program in imem until HALT, queueing the
   // expected fetch addresses and register-write values
   task automatic runModel();
      int pc = 0;
      int steps = 0;
      bit done = 1'b0;
      logic [15:0] ins, a, b, y;
      logic [3:0] op;
      int d, s1, s2, imm, npc, sr, sh;
      while (!done && steps < 500) begin
         exp_fetch.push_back(pc);
         ins = imem[pc];
         op  = ins[15:12];
         d   = int'(ins[11:9]);
         s1  = int'(ins[8:6]);
         s2  = int'(ins[5:3]);
         imm = int'(ins[8:0]);
         a   = mregs[s1];
         b   = mregs[s2];
         sh  = int'(b) % 16;
         npc = (pc + 1) % 128;
         case (op)
            OP_ADD: begin
               sr = int'(a) + int'(b);
               y  = 16'(sr % 65536);
               mc = (sr > 65535);
               mv = (sgn(a) + sgn(b) > 32767) || (sgn(a) + sgn(b) < -32768);
               mz = (y == 16'h0); mn = (y >= 16'h8000);
               modelWrite(d, y);
            end
            OP_SUB, OP_CMP: begin
               sr = int'(a) - int'(b);
               y  = 16'((sr + 65536) % 65536);
               mc = (int'(a) >= int'(b));
               mv = (sgn(a) - sgn(b) > 32767) || (sgn(a) - sgn(b) < -32768);
               mz = (y == 16'h0); mn = (y >= 16'h8000);
               if (op == OP_SUB) modelWrite(d, y);
            end
            OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
               case (op)
                  OP_AND:  y = a & b;
                  OP_OR:   y = a | b;
                  OP_XOR:  y = a ^ b;
                  OP_SHL:  y = 16'((longint'(a) * (longint'(1) << sh)) % 65536);
                  default: y = 16'(int'(a) / (1 << sh));
               endcase
               mz = (y == 16'h0); mn = (y >= 16'h8000); mv = 1'b0; mc = 1'b0;
               modelWrite(d, y);
            end
            OP_LDI:  modelWrite(d, 16'(imm));
            OP_LD:   modelWrite(d, mdm[int'(a) % 128]);
            OP_ST:   mdm[int'(a) % 128] = b;
            OP_BZ:   if (mz) npc = imm % 128;
            OP_JMP:  npc = imm % 128;
            OP_HALT: done = 1'b1;
            default: ;
         endcase
         pc = npc;
         steps++;
      end
      model_overrun = !done;
   endtask

   task automatic checkResetState(input string where);
      checkOutput({where, "_busy"}, busy, 0);
      checkOutput({where, "_halted"}, halted, 0);
      checkOutput({where, "_imem_req"}, bus.imem_req, 0);
      checkOutput({where, "_imem_addr"}, bus.imem_addr, 0);
      checkOutput({where, "_dmem_re_we"}, {bus.dmem_re, bus.dmem_we}, 0);
      checkOutput({where, "_dmem_addr"}, bus.dmem_addr, 0);
      checkOutput({where, "_dmem_wdata"}, bus.dmem_wdata, 0);
      checkOutput({where, "_result"}, result, 0);
      checkOutput({where, "_result_valid"}, result_valid, 0);
      checkOutput({where, "_flags"}, {zero, negative, overflow, carry}, 0);
   endtask

   // Reset pulse with start held high to show that reset has priority
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      modelReset();
   endtask

   task automatic clearImem();
      for (int i = 0; i < 128; i++) imem[i] = encI(OP_HALT, 0, 0);
   endtask

   // Start the loaded program, poke start while busy, wait for HALT, score it
   task automatic applyStimulus(input string tag, output int cycles);
      fetch_log.delete();
      req_len_q.delete();
      mdm = dmem;
      runModel();
      checkOutput({tag, "_model_halts"}, model_overrun, 0);
      @(negedge clk);
      start = 1'b1;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         start = busy && ($urandom_range(0, 3) == 0);
      end while (!halted && cycles < 3000);
      start = 1'b0;
      checkOutput({tag, "_halted"}, halted, 1);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_flags"}, {zero, negative, overflow, carry}, {mz, mn, mv, mc});
      checkOutput({tag, "_last_result"}, result, m_last);
      checkOutput({tag, "_fetch_left"}, exp_fetch.size(), 0);
      checkOutput({tag, "_writes_left"}, exp_result.size(), 0);
      exp_fetch.delete();
      exp_result.delete();
   endtask

   // Instruction memory responder with per-fetch wait states
   initial begin
      int cnt = 0;
      int wt = 0;
      int first_addr = 0;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.imem_req) begin
            if (cnt == 0) first_addr = int'(bus.imem_addr);
            else checkOutput("imem_addr_stable", bus.imem_addr, first_addr);
            if (cnt >= wt) begin
               bus.imem_valid = 1'b1;
               bus.imem_rdata = imem[bus.imem_addr];
               req_len_q.push_back(cnt + 1);
               fetch_log.push_back(int'(bus.imem_addr));
               if (exp_fetch.size() == 0) checkOutput("fetch_unexpected", bus.imem_addr, 32'h1_0000);
               else checkOutput("fetch_addr", bus.imem_addr, exp_fetch.pop_front());
            end else begin
               bus.imem_valid = 1'b0;
            end
            cnt++;
         end else begin
            bus.imem_valid = 1'b0;
            cnt = 0;
            wt = (iwait_fixed >= 0) ? iwait_fixed : int'($urandom_range(0, 2));
         end
      end
   end

   // Data memory responder with per-access wait states
   initial begin
      int cnt = 0;
      int wt = 0;
      bus.dmem_valid = 1'b0;
      bus.dmem_rdata = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         if (dmem_auto) begin
            if (bus.dmem_re || bus.dmem_we) begin
               if (cnt >= wt) begin
                  bus.dmem_valid = 1'b1;
                  if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
                  if (bus.dmem_re) bus.dmem_rdata = dmem[bus.dmem_addr];
               end else begin
                  bus.dmem_valid = 1'b0;
               end
               cnt++;
            end else begin
               bus.dmem_valid = 1'b0;
               cnt = 0;
               wt = (dwait_fixed >= 0) ? dwait_fixed : int'($urandom_range(0, 2));
            end
         end
      end
   end

   // Every register-file write must match the next value the model predicts
   initial begin
      forever begin
         @(negedge clk);
         if (result_valid) begin
            if (exp_result.size() == 0) checkOutput("result_unexpected", result, 32'h1_0000);
            else checkOutput("result", result, exp_result.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int k;
      int n;
      logic [3:0] op;
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 128; i++) dmem[i] = 16'($urandom);
      modelReset();
      doReset();
      checkResetState("reset");

      // Basic add, zero wait states: 4 instructions x 2 cycles after start
      iwait_fixed = 0;
      dwait_fixed = 0;
      clearImem();
      imem[0] = encI(OP_LDI, 1, 5);
      imem[1] = encI(OP_LDI, 2, 7);
      imem[2] = encR(OP_ADD, 3, 1, 2);
      applyStimulus("add", cyc);
      checkOutput("add_result", result, 12);
      checkOutput("add_latency", cyc, 9);
      checkOutput("add_fetch_count", fetch_log.size(), 4);
      checkOutput("add_fetch3", (fetch_log.size() > 3) ? fetch_log[3] : -1, 3);

      // Shift into the sign bit, then subtract across the signed boundary
      clearImem();
      imem[0] = encI(OP_LDI, 1, 1);
      imem[1] = encI(OP_LDI, 2, 15);
      imem[2] = encR(OP_SHL, 3, 1, 2);
      applyStimulus("shl", cyc);
      checkOutput("shl_result", result, 16'h8000);
      checkOutput("shl_flags", {zero, negative, overflow, carry}, 4'b0100);
      clearImem();
      imem[0] = encR(OP_SUB, 4, 3, 1);
      applyStimulus("sub", cyc);
      checkOutput("sub_result", result, 16'h7FFF);
      checkOutput("sub_flags", {zero, negative, overflow, carry}, 4'b0011);

      // Slow instruction memory: request held for 4 cycles on each fetch
      iwait_fixed = 3;
      clearImem();
      imem[0] = encI(OP_LDI, 1, 5);
      applyStimulus("slow_fetch", cyc);
      checkOutput("slow_req_len", (req_len_q.size() > 0) ? req_len_q[0] : -1, 4);
      iwait_fixed = 0;

      // Taken BZ, JMP with a high imm9 bit, PC wrap from 0x7F to 0x00
      doReset();
      clearImem();
      imem[0]     = encI(OP_BZ, 0, 9'h020);
      imem[1]     = encR(OP_CMP, 0, 1, 1);
      imem[2]     = encI(OP_BZ, 0, 9'h010);
      imem[16]    = encI(OP_JMP, 0, 9'h17F);
      imem[127]   = encI(OP_NOP, 0, 0);
      applyStimulus("branch", cyc);
      checkOutput("branch_fetch_count", fetch_log.size(), 7);
      if (fetch_log.size() == 7) begin
         checkOutput("branch_bz_target", fetch_log[3], 16);
         checkOutput("branch_jmp_target", fetch_log[4], 127);
         checkOutput("branch_wrap", fetch_log[5], 0);
         checkOutput("branch_second_bz", fetch_log[6], 32);
      end
      checkOutput("branch_flags", {zero, negative, overflow, carry}, 4'b1001);

      // Store 0xABCD to [3] then load it back with a slow data memory
      dwait_fixed = 2;
      clearImem();
      imem[0] = encI(OP_LDI, 5, 9'hAB);
      imem[1] = encI(OP_LDI, 1, 8);
      imem[2] = encR(OP_SHL, 5, 5, 1);
      imem[3] = encI(OP_LDI, 2, 9'hCD);
      imem[4] = encR(OP_OR, 5, 5, 2);
      imem[5] = encI(OP_LDI, 6, 3);
      imem[6] = encR(OP_ST, 0, 6, 5);
      imem[7] = encR(OP_LD, 7, 6, 0);
      applyStimulus("st_ld", cyc);
      checkOutput("st_ld_result", result, 16'hABCD);
      checkOutput("st_ld_dmem", dmem[3], 16'hABCD);

      // Reset in the middle of a load; a late dmem_valid must be ignored
      doReset();
      clearImem();
      imem[0] = encI(OP_LDI, 6, 3);
      imem[1] = encR(OP_LD, 7, 6, 0);
      exp_fetch.push_back(0);
      exp_fetch.push_back(1);
      exp_result.push_back(3);
      dmem_auto = 1'b0;
      bus.dmem_valid = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!bus.dmem_re && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput("abort_dmem_re", bus.dmem_re, 1);
      checkOutput("abort_dmem_addr", bus.dmem_addr, 3);
      checkOutput("abort_writes_left", exp_result.size(), 0);
      checkOutput("abort_fetch_left", exp_fetch.size(), 0);
      doReset();
      bus.dmem_valid = 1'b1;
      bus.dmem_rdata = 16'h5555;
      repeat (2) @(negedge clk);
      checkResetState("abort");
      bus.dmem_valid = 1'b0;
      dmem_auto = 1'b1;
      exp_fetch.delete();
      exp_result.delete();

      // Random forward-only programs with random wait states
      iwait_fixed = -1;
      dwait_fixed = -1;
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 4) == 0) begin
            doReset();
         end
         clearImem();
         n = int'($urandom_range(6, 16));
         for (int p = 0; p < n; p++) begin
            op = 4'($urandom_range(0, 14));
            if (op == OP_BZ || op == OP_JMP) imem[p] = encI(op, 0, int'($urandom_range(p + 1, n)));
            else if (op == OP_LDI) imem[p] = encI(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 511)));
            else imem[p] = encR(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         end
         applyStimulus("random", cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/proc_param.md
PROC_PARAM -- requirements
Module: proc_param

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width (8..32).
REQ-002 Parameter PC_W, default 7, program-address width (2..9).
REQ-003 Parameter DMEM_AW, default 7, data-memory address width (<= DATA_W).
REQ-004 Port clk input 1 sole clock, rising edge; one clock domain.
REQ-005 Port rst input 1 reset, synchronous, active-high.
REQ-006 Port start input 1: begin execution at PC 0.
REQ-007 Ports imem_req output 1, imem_addr output PC_W, imem_rdata input 16, imem_valid input 1: instruction fetch.
REQ-008 Ports dmem_re output 1, dmem_we output 1, dmem_addr output DMEM_AW, dmem_wdata output DATA_W, dmem_rdata input DATA_W, dmem_valid input 1: data memory.
REQ-009 Ports result output DATA_W, result_valid output 1: register-file write value, with a one-cycle pulse on each write.
REQ-010 Ports zero, negative, overflow, carry output 1 each: registered flags.
REQ-011 Ports busy output 1 and halted output 1: core status.

Function
REQ-012 Instruction fields: [15:12] opcode, [11:9] dest, [8:6] src1, [5:3] src2, [8:0] imm9; 8 registers r0..r7, all writable.
REQ-013 Opcodes:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
- 6 SHL and 7 SHR (logical), shift amount = src2 low clog2(DATA_W) bits
- 8 LDI: dest <= zero-extended imm9, truncated to DATA_W
- 9 LD: dest <= mem[src1]
- 10 ST: mem[src1] <= src2
- 11 BZ: if zero, PC <= imm9[PC_W-1:0]
- 12 JMP: PC <= imm9[PC_W-1:0]
- 13 CMP: src1-src2, flags only
- 14 NOP
- 15 HALT
REQ-014 States: IDLE, FETCH, EXEC, MEM, HALT.
REQ-015 IDLE: start -> FETCH, PC <= 0. HALT: halted=1; start -> FETCH, PC <= 0. Registers and flags are retained in both.
REQ-016 FETCH: imem_req=1 and imem_addr=PC, both held stable until imem_valid; the instruction is latched, then -> EXEC. imem_valid is ignored in all other states.
REQ-017 EXEC, one cycle:
- ALU ops and LDI write dest and pulse result_valid.
- BZ/JMP update PC; all other ops PC <= PC+1, wrapping 2^PC_W-1 -> 0.
- Next state: LD/ST -> MEM; HALT -> HALT; otherwise -> FETCH.
REQ-018 MEM: dmem_re (LD) or dmem_we (ST) held with dmem_addr = src1[DMEM_AW-1:0] and dmem_wdata = src2 until dmem_valid. LD writes dest and pulses result_valid in the dmem_valid cycle; -> FETCH.
REQ-019 Minimum latency with zero wait states: 2 cycles per non-memory instruction, 3 per LD/ST.
REQ-020 Flags:
- ADD/SUB/CMP update Z, N, V (signed overflow), C (ADD carry-out; SUB/CMP C = no-borrow, src1 >= src2 unsigned).
- Logic and shift ops update Z, N and clear V, C.
- LDI, LD, ST, branches, NOP and HALT leave flags unchanged.
REQ-021 Results truncate to DATA_W.
REQ-022 busy = 1 in FETCH, EXEC and MEM; start is ignored while busy.
REQ-023 BZ tests flags as they stand before the BZ.
REQ-024 Undefined imm9 bits above PC_W are ignored.

Reset
REQ-025 While rst=1, at the next edge: state IDLE, PC 0, all registers 0, flags 0, result 0, and all outputs deasserted (busy, halted, imem_req, dmem_re, dmem_we, result_valid), addresses and wdata 0.
REQ-026 rst mid-FETCH or mid-MEM aborts the access with no register write; the outstanding dmem_valid/imem_valid is then ignored.
REQ-027 rst has priority over start.

Structure
REQ-028 Package proc_param_pkg holds opcode constants, the state encoding and instruction field positions.
REQ-029 The datapath is a combinational sub-module proc_param_alu (opcode, operands, shift amount -> result, Z/N/V/C), parametrised by DATA_W.
REQ-030 The register file is an 8 x DATA_W flop array inside proc_param.

Verification (DATA_W=16, PC_W=7)
REQ-031 LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT -> result 12 with result_valid on the ADD EXEC cycle; imem_addr 0,1,2,3; halted=1; busy=0.
REQ-032 LDI r1,1; LDI r2,15; SHL r3,r1,r2 -> 0x8000, N=1; SUB r4,r3,r1 -> 0x7FFF, V=1, C=1, N=0.
REQ-033 imem_valid delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; no result_valid.
REQ-034 CMP r1,r1 -> Z=1, then BZ 0x10 -> next imem_addr 0x10. JMP 0x7F with NOP at 0x7F -> next imem_addr 0x00.
REQ-035 ST r5->[r6=3] with value 0xABCD, then LD r7,[r6] with dmem_valid after 2 cycles -> result 0xABCD. A repeat with rst asserted during MEM -> IDLE, no result_valid, all outputs at reset values.
